// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: data widths, the canonical NOP and the
// fetch-queue entry layout reused by decode and later stages.
package cpu_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage : cpu_pkg

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode valid/ready handshake carrying the head {pc, instr} pair.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic            valid;
  logic            ready;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] pc;

  modport master (output valid, output instr, output pc, input ready);
  modport slave  (input valid, input instr, input pc, output ready);

endinterface : fetch_unit_if

// File: rtl/fetch_fifo.sv
// Small circular queue of fetch entries with push, pop and a flush that
// empties the queue and rewinds both pointers.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every use of its contents.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, indexes the combinational icache and
// queues {pc, instr} pairs for decode; execute redirects flush the queue.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            fetch_en_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [31:0]     ic_addr_o,
  input  logic [ILEN-1:0] ic_rdata_i,
  fetch_unit_if.master    id
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    fifo_din;
  fetch_entry_t    fifo_dout;
  logic            push;
  logic            pop;
  logic            head_valid;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  assign head_valid = (fifo_count != '0);
  assign pop        = head_valid & id.ready;
  // A full queue still accepts a fetch when decode frees the head this cycle.
  assign push       = fetch_en_i & ~redirect_i &
                      ((fifo_count < CW'(DEPTH)) | pop);

  assign fifo_din.pc    = pc_q;
  assign fifo_din.instr = ic_rdata_i;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + 64'd4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign ic_addr_o = pc_q[33:2];
  assign id.valid  = head_valid;
  assign id.instr  = head_valid ? fifo_dout.instr : NOP_INSTR;
  assign id.pc     = head_valid ? fifo_dout.pc    : '0;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: icache word k returns 32'h1000_0000 + k.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        fetch_en;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] ic_addr;
  logic [31:0] ic_rdata;
  int          n_cmp = 0;
  int          n_err = 0;

  fetch_unit_if id_if ();

  fetch_unit #(
    .RESET_PC(64'h0),
    .DEPTH   (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .fetch_en_i   (fetch_en),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .ic_addr_o    (ic_addr),
    .ic_rdata_i   (ic_rdata),
    .id           (id_if)
  );

  assign ic_rdata = 32'h1000_0000 + ic_addr;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [63:0] pc, input logic [31:0] instr);
    chk({tag, "_valid"}, {63'd0, id_if.valid}, 64'd1);
    chk({tag, "_pc"},    id_if.pc, pc);
    chk({tag, "_instr"}, {32'd0, id_if.instr}, {32'd0, instr});
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, {63'd0, id_if.valid}, 64'd0);
    chk({tag, "_pc"},    id_if.pc, 64'd0);
    chk({tag, "_instr"}, {32'd0, id_if.instr}, 64'h13);
  endtask

  task automatic do_reset(input logic ready);
    rst_ni      = 1'b0;
    fetch_en    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_if.ready = ready;
    step();
    chk_empty("rst");
    chk("rst_icaddr", {32'd0, ic_addr}, 64'd0);
    chk("rst_count", {61'd0, dut.fifo_count}, 64'd0);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni      = 1'b0;
    fetch_en    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_if.ready = 1'b0;
    step();

    // 1: streaming from reset
    do_reset(1'b1);
    chk_empty("t1_first");
    step(); chk_head("t1_e1", 64'h0, 32'h1000_0000);
    step(); chk_head("t1_e2", 64'h4, 32'h1000_0001);
    step(); chk_head("t1_e3", 64'h8, 32'h1000_0002);

    // 2: backpressure saturates the queue
    do_reset(1'b0);
    repeat (5) step();
    chk("t2_count", {61'd0, dut.fifo_count}, 64'd2);
    chk("t2_icaddr", {32'd0, ic_addr}, 64'd2);
    chk_head("t2_hold", 64'h0, 32'h1000_0000);
    id_if.ready = 1'b1;
    step(); chk_head("t2_d1", 64'h4, 32'h1000_0001);
    step(); chk_head("t2_d2", 64'h8, 32'h1000_0002);
    step(); chk_head("t2_d3", 64'hc, 32'h1000_0003);

    // 3: redirect while holding pc 4 and 8
    do_reset(1'b0);
    step(); step();
    id_if.ready = 1'b1;
    step();
    chk("t3_count", {61'd0, dut.fifo_count}, 64'd2);
    chk_head("t3_pre", 64'h4, 32'h1000_0001);
    id_if.ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h40;
    step();
    redirect = 1'b0;
    chk_empty("t3_flush");
    chk("t3_icaddr", {32'd0, ic_addr}, 64'h10);
    step(); chk_head("t3_tgt", 64'h40, 32'h1000_0010);

    // 4: redirect coinciding with a pop of pc 8, unaligned target
    do_reset(1'b0);
    step(); step();
    id_if.ready = 1'b1;
    step(); step();
    chk_head("t4_pre", 64'h8, 32'h1000_0002);
    redirect    = 1'b1;
    redirect_pc = 64'h83;
    step();
    redirect = 1'b0;
    chk_empty("t4_flush");
    chk("t4_count", {61'd0, dut.fifo_count}, 64'd0);
    step(); chk_head("t4_tgt", 64'h80, 32'h1000_0020);

    // 5: fetch disabled drains the queue and freezes the PC
    do_reset(1'b0);
    step(); step();
    fetch_en    = 1'b0;
    id_if.ready = 1'b1;
    step(); chk_head("t5_d1", 64'h4, 32'h1000_0001);
    step(); chk_empty("t5_e1");
    chk("t5_icaddr1", {32'd0, ic_addr}, 64'd2);
    step(); chk_empty("t5_e2");
    chk("t5_icaddr2", {32'd0, ic_addr}, 64'd2);

    // 6: reset wins over redirect, push and pop on the same edge
    fetch_en = 1'b1;
    step(); chk_head("t6_run1", 64'h8, 32'h1000_0002);
    step(); chk_head("t6_run2", 64'hc, 32'h1000_0003);
    rst_ni      = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h40;
    step();
    chk_empty("t6_rst");
    chk("t6_count", {61'd0, dut.fifo_count}, 64'd0);
    chk("t6_icaddr", {32'd0, ic_addr}, 64'd0);
    rst_ni   = 1'b1;
    redirect = 1'b0;
    step(); chk_head("t6_r1", 64'h0, 32'h1000_0000);
    step(); chk_head("t6_r2", 64'h4, 32'h1000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the decode stage in CPU. It owns the PC, drives the combinational icache, and buffers fetched {pc, instr} pairs in a small FIFO. The FIFO feeds decode through a valid/ready handshake. Execute can redirect the PC for branches and jumps, which flushes everything already fetched.

Parameters:
RESET_PC, 64'h0, PC loaded on reset (byte address, bits[1:0] must be 0)
DEPTH, 2, FIFO entries; power of two, >= 2

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  reset, synchronous, active-low
fetch_en_i  in  1  fetch enable; low = no new fetches, FIFO still drains
redirect_i  in  1  PC redirect request from execute
redirect_pc_i  in  64  redirect target (byte address; bits[1:0] ignored, treated as 0)
ic_addr_o  out  32  icache word index = pc[33:2]
ic_rdata_i  in  32  icache read data, combinational from ic_addr_o
id_valid_o  out  1  head entry valid for decode
id_ready_i  in  1  decode accepts head entry
id_instr_o  out  32  head instruction
id_pc_o  out  64  head PC

Behaviour:
- Reset (rst_ni=0 at a rising edge):
  - pc <= RESET_PC; FIFO empty; count <= 0.
  - Outputs during and after reset: id_valid_o=0, id_instr_o=32'h00000013 (NOP), id_pc_o=0, ic_addr_o=RESET_PC[33:2].
- Handshake:
  - pop = id_valid_o & id_ready_i.
  - id_valid_o = (count != 0).
  - id_instr_o and id_pc_o show the FIFO head when valid, and NOP/0 when empty.
  - Outputs come straight from FIFO storage, so there is no combinational path from ic_rdata_i to id_*.
- Push:
  - push = fetch_en_i & ~redirect_i & ((count < DEPTH) | pop).
  - On push, the FIFO writes {pc, ic_rdata_i} at the tail and pc <= pc + 4.
  - Without push, pc holds.
  - Push when full is allowed only with a simultaneous pop; count then stays at DEPTH.
- Latency: an instruction fetched in cycle N appears on id_* in cycle N+1. With id_ready_i held high, throughput is 1 instr/cycle.
- Redirect (redirect_i=1 sampled at edge N):
  - FIFO is flushed (count <= 0, pointers reset) and pc <= {redirect_pc_i[63:2], 2'b00}.
  - No push in that cycle.
  - Target instruction is pushed at edge N+1 and is valid on id_* after edge N+1.
- Redirect with simultaneous pop: the handshake completes (decode keeps the entry) and the flush still clears all remaining entries.
- Redirect with fetch_en_i=0: PC is still loaded and the FIFO still flushed.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits, ranging 0..DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance.
- PC arithmetic is 64-bit and wraps at 2^64 silently.
- Reset mid-operation: reset overrides redirect, push and pop in the same edge.
- fetch_en_i=0: pc holds and there are no pushes; existing entries still drain through the handshake.

Decomposition:
- Shared package cpu_pkg:
  - XLEN=64, ILEN=32, NOP_INSTR=32'h00000013.
  - typedef struct packed {logic [XLEN-1:0] pc; logic [ILEN-1:0] instr;} fetch_entry_t.
  - decode and later stages reuse these definitions.
- Sub-module fetch_fifo (parameter DEPTH, element type fetch_entry_t):
  - ports: push, pop, flush, din, dout, count.
  - fetch_unit keeps the PC register, the push/redirect logic and the output muxing.

Test Plan:
1. Reset release with RESET_PC=0, fetch_en_i=1, id_ready_i=1, icache word k = 32'h1000_0000+k -> first cycle after reset id_valid_o=0; then pc 0,4,8 are presented on consecutive cycles with instr 10000000, 10000001, 10000002.
2. Backpressure: id_ready_i=0 for 5 cycles from reset -> count saturates at 2, pc stops at 8, id_pc_o holds 0. Release id_ready_i -> outputs 0,4,8,12 in order with no gap or duplicate.
3. Redirect: redirect_i=1 with redirect_pc_i=64'h40 while FIFO holds pc 4 and 8 -> next cycle id_valid_o=0; cycle after that id_pc_o=64'h40, id_instr_o=word 16.
4. Redirect with pop: redirect_i=1, redirect_pc_i=64'h83, id_ready_i=1, head pc=8 -> decode takes pc 8, FIFO flushed, next valid entry is pc 64'h80.
5. fetch_en_i=0 with 2 queued entries and id_ready_i=1 -> both drain, then id_valid_o=0, id_instr_o=32'h13, ic_addr_o constant.
6. Reset mid-stream: rst_ni=0 at the same edge as redirect_i=1 and pop -> pc=RESET_PC, id_valid_o=0, count=0; normal fetch resumes from RESET_PC.
